// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage.
package rv32_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with misaligned-redirect detection.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps to TRAP_VECTOR);
// without it, redirect targets are forced to word alignment and misalign_o stays 0.
module pc_next_sel
  import rv32_fetch_pkg::*;
`ifdef PC_MISALIGN_TRAP_EN
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
)
`endif
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] sel_target;

  // Priority: halt > stall (both freeze) > jalr > branch > sequential.
  always_comb begin
    sel_target = jalr_i ? (jalr_target_i & ~XLEN'(1)) : branch_target_i;
    next_pc_o  = pc_plus4_i;
    misalign_o = 1'b0;
    if (halt_i || stall_i) begin
      next_pc_o = pc_i;
    end else if (jalr_i || branch_taken_i) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (sel_target[1:0] != 2'b00) begin
        next_pc_o  = TRAP_VECTOR;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = sel_target;
      end
`else
      next_pc_o = sel_target & ~XLEN'(3);
`endif
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / fetch stage feeding the instruction ROM: PC register, BOOT/RUN/HALT
// run state, retired-fetch counter and misaligned-trap pulse.
// Optional feature macro: PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  halt_i,
  input  logic                  branch_taken_i,
  input  logic [31:0]           branch_target_i,
  input  logic                  jalr_i,
  input  logic [31:0]           jalr_target_i,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_plus4_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  output logic                  fetch_valid_o,
  output logic                  out_of_range_o,
  output logic                  halted_o,
  output logic                  misaligned_o,
  output logic [31:0]           retired_o
);

  // A trap vector must itself be a legal fetch address.
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_fetch_unit: TRAP_VECTOR must be word aligned");
  end

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     retired_q, retired_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] sel_next_pc;
  logic            sel_misalign;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

`ifdef PC_MISALIGN_TRAP_EN
  pc_next_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_sel (
`else
  pc_next_sel u_next_sel (
`endif
    .pc_i           (pc_q),
    .pc_plus4_i     (pc_plus4),
    .halt_i         (halt_i),
    .stall_i        (stall_i),
    .jalr_i         (jalr_i),
    .jalr_target_i  (jalr_target_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .next_pc_o      (sel_next_pc),
    .misalign_o     (sel_misalign)
  );

  // Run-state transitions, PC update, retire count and trap pulse.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retired_d    = retired_q;
    misaligned_d = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        pc_d         = sel_next_pc;
        misaligned_d = sel_misalign;
        if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          retired_d = retired_q + 32'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      retired_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign read_address_o = pc_q[ADDR_WIDTH-1:0];
  assign out_of_range_o = |pc_q[31:ADDR_WIDTH];
  assign fetch_valid_o  = (state_q == RUN);
  assign halted_o       = (state_q == HALT);
  assign misaligned_o   = misaligned_q;
  assign retired_o      = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed steps plus randomized
// traffic, checked against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam int unsigned ADDR_WIDTH  = 10;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  stall_i = 1'b0;
  logic                  halt_i = 1'b0;
  logic                  branch_taken_i = 1'b0;
  logic [31:0]           branch_target_i = '0;
  logic                  jalr_i = 1'b0;
  logic [31:0]           jalr_target_i = '0;
  logic [31:0]           pc_o;
  logic [31:0]           pc_plus4_o;
  logic [ADDR_WIDTH-1:0] read_address_o;
  logic                  fetch_valid_o;
  logic                  out_of_range_o;
  logic                  halted_o;
  logic                  misaligned_o;
  logic [31:0]           retired_o;

  pc_fetch_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC),
    .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .halt_i         (halt_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jalr_i         (jalr_i),
    .jalr_target_i  (jalr_target_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .read_address_o (read_address_o),
    .fetch_valid_o  (fetch_valid_o),
    .out_of_range_o (out_of_range_o),
    .halted_o       (halted_o),
    .misaligned_o   (misaligned_o),
    .retired_o      (retired_o)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_mis;
  string       m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply the architectural rules for one rising edge using the driven inputs.
  task automatic model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RESET_PC; m_phase = "BOOT"; m_ret = 0; m_mis = 0;
    end else if (m_phase == "BOOT") begin
      m_phase = "RUN"; m_mis = 0;
    end else if (m_phase == "RUN") begin
      m_mis = 0;
      if (halt_i) begin
        m_phase = "HALT";
      end else if (!stall_i) begin
        m_ret = m_ret + 1;
        if (jalr_i || branch_taken_i) begin
          tgt = jalr_i ? jalr_target_i - (jalr_target_i % 2) : branch_target_i;
`ifdef PC_MISALIGN_TRAP_EN
          if (tgt % 4 != 0) begin
            m_pc = TRAP_VECTOR; m_mis = 1;
          end else begin
            m_pc = tgt;
          end
`else
          m_pc = tgt - (tgt % 4);
`endif
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end else begin
      m_mis = 0;
    end
  endtask

  task automatic check_all();
    check("pc", pc_o, m_pc);
    check("pc_plus4", pc_plus4_o, m_pc + 4);
    check("read_address", 32'(read_address_o), m_pc % (1 << ADDR_WIDTH));
    check("out_of_range", 32'(out_of_range_o), 32'((m_pc >> ADDR_WIDTH) != 0));
    check("fetch_valid", 32'(fetch_valid_o), 32'(m_phase == "RUN"));
    check("halted", 32'(halted_o), 32'(m_phase == "HALT"));
    check("misaligned", 32'(misaligned_o), 32'(m_mis));
    check("retired", retired_o, m_ret);
  endtask

  task automatic step(input logic r, input logic h, input logic s,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst = r; halt_i = h; stall_i = s;
    branch_taken_i = b; branch_target_i = bt;
    jalr_i = j; jalr_target_i = jt;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic branch_to(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] ret_snap;
    logic [31:0] bt, jt;

    // Reset and free run.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_pc", pc_o, 32'h0);
    check("reset_fetch_valid", 32'(fetch_valid_o), 32'h0);
    idle();
    idle();
    idle();
    check("free_run_pc", pc_o, 32'h8);
    check("free_run_retired", retired_o, 32'd2);
    idle();

    // JALR beats a simultaneous branch; bit 0 of the JALR target cleared.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h81);
    check("jalr_over_branch", pc_o, 32'h80);

    // Stall holds PC despite a taken branch.
    branch_to(32'h10);
    ret_snap = retired_o;
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, '0);
    check("stall_pc", pc_o, 32'h10);
    check("stall_retired", retired_o, ret_snap);

    // Misaligned branch target.
    branch_to(32'h42);
`ifdef PC_MISALIGN_TRAP_EN
    check("trap_pc", pc_o, 32'h100);
    check("trap_pulse", 32'(misaligned_o), 32'h1);
    idle();
    check("trap_pulse_end", 32'(misaligned_o), 32'h0);
`else
    check("aligned_branch_pc", pc_o, 32'h40);
    check("no_trap_pulse", 32'(misaligned_o), 32'h0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h83);

    // Wrap past the top of the address space, then out-of-range.
    branch_to(32'hFFFF_FFFC);
    check("near_wrap_oor", 32'(out_of_range_o), 32'h1);
    idle();
    check("wrap_pc", pc_o, 32'h0);
    branch_to(32'h400);
    check("oor_0x400", 32'(out_of_range_o), 32'h1);
    check("oor_0x400_addr", 32'(read_address_o), 32'h0);

    // Halt wins over stall and redirects; HALT absorbs until reset.
    branch_to(32'h20);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 32'h48);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h48);
    check("halt_pc", pc_o, 32'h20);
    check("halt_flag", 32'(halted_o), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, '0);
    check("halt_reset_pc", pc_o, RESET_PC);
    check("halt_reset_boot", 32'(fetch_valid_o | halted_o), 32'h0);

    // Randomized traffic, including occasional halts and resets.
    for (int i = 0; i < 400; i++) begin
      bt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h7FF);
      jt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h7FF);
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0), bt,
           1'($urandom_range(0, 4) == 0), jt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
